// File: rtl/cgra_cfg_pkg.sv
// Shared types and helpers for the CGRA configuration chain loader and its
// host-side bitstream tooling.
package cgra_cfg_pkg;

  localparam int CFG_WORD_W = 32;

  typedef enum logic [2:0] {
    CFG_IDLE,
    CFG_CLEAR,
    CFG_FETCH,
    CFG_SHIFT,
    CFG_DONE
  } cfg_state_e;

  // Number of host words needed to cover a chain of len bits.
  function automatic int cfg_words(input int len, input int w);
    return (len + w - 1) / w;
  endfunction

endpackage

// File: rtl/cgra_config_loader_if.sv
// Host word handshake into the configuration loader.
interface cgra_config_loader_if
  import cgra_cfg_pkg::*;
#(
  parameter int WORD_W = CFG_WORD_W
);
  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic              word_ready;

  modport master (output word_valid, word_data, input word_ready);
  modport slave  (input word_valid, word_data, output word_ready);
endinterface

// File: rtl/cfg_piso.sv
// Parallel-in serial-out word register; bit 0 is the bit on the chain this cycle.
module cfg_piso
  import cgra_cfg_pkg::*;
#(
  parameter int WORD_W = CFG_WORD_W,
  parameter int RC_W   = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] din,
  input  logic [RC_W-1:0]   load_cnt,
  output logic              dout,
  output logic [RC_W-1:0]   rem
);

  logic [WORD_W-1:0] shreg;

  // Emptying the register on the last counted bit keeps the discarded upper
  // bits of a partial word off the chain and holds dout at 0 between words.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      shreg <= '0;
      rem   <= '0;
    end else if (load) begin
      shreg <= din;
      rem   <= load_cnt;
    end else if (shift && rem != '0) begin
      rem   <= rem - RC_W'(1);
      shreg <= (rem == RC_W'(1)) ? '0 : (shreg >> 1);
    end
  end

  assign dout = shreg[0];

endmodule

// File: rtl/cgra_config_loader.sv
// Serialises host configuration words onto the tile config chain, LSB first,
// with a leading chain-wide clear pulse and a registered shift enable.
module cgra_config_loader
  import cgra_cfg_pkg::*;
#(
  parameter int WORD_W    = CFG_WORD_W,
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  cgra_config_loader_if.slave  host,
  output logic                 cfg_reset,
  output logic                 cfg_shift_en,
  output logic                 cfg_data,
  output logic                 busy,
  output logic                 done
);

  localparam int RC_W = $clog2(WORD_W + 1);

  cfg_state_e       state;
  logic             word_ready;
  logic [CNT_W-1:0] bits_sent;
  logic [CNT_W-1:0] bits_sent_nxt;
  logic [RC_W-1:0]  rem;
  logic [RC_W-1:0]  load_cnt;
  logic [31:0]      bits_left;
  logic             hs;

  assign host.word_ready = word_ready;
  assign hs              = host.word_valid && word_ready;
  assign bits_sent_nxt   = bits_sent + CNT_W'(1);

  // The final word may be partial: only the bits still owed to the chain count.
  always_comb begin
    bits_left = 32'(CHAIN_LEN) - 32'(bits_sent);
    load_cnt  = (bits_left >= 32'(WORD_W)) ? RC_W'(WORD_W) : RC_W'(bits_left);
  end

  cfg_piso #(.WORD_W(WORD_W), .RC_W(RC_W)) u_piso (
    .clk      (clk),
    .reset    (reset),
    .clr      (state == CFG_CLEAR),
    .load     ((state == CFG_FETCH) && hs),
    .shift    (state == CFG_SHIFT),
    .din      (host.word_data),
    .load_cnt (load_cnt),
    .dout     (cfg_data),
    .rem      (rem)
  );

  // Outputs are set on the transition into the state that owns them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= CFG_IDLE;
      word_ready   <= 1'b0;
      cfg_reset    <= 1'b0;
      cfg_shift_en <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      bits_sent    <= '0;
    end else begin
      case (state)
        CFG_IDLE, CFG_DONE: begin
          if (start) begin
            state     <= CFG_CLEAR;
            cfg_reset <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        CFG_CLEAR: begin
          state      <= CFG_FETCH;
          cfg_reset  <= 1'b0;
          word_ready <= 1'b1;
          bits_sent  <= '0;
        end
        CFG_FETCH: begin
          if (hs) begin
            state        <= CFG_SHIFT;
            word_ready   <= 1'b0;
            cfg_shift_en <= 1'b1;
          end
        end
        CFG_SHIFT: begin
          bits_sent <= bits_sent_nxt;
          if (rem == RC_W'(1)) begin
            cfg_shift_en <= 1'b0;
            if (bits_sent_nxt == CNT_W'(CHAIN_LEN)) begin
              state <= CFG_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state      <= CFG_FETCH;
              word_ready <= 1'b1;
            end
          end
        end
        default: state <= CFG_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cgra_config_loader.sv
// Scenario bench for the config loader: one 64-bit chain and one 40-bit chain.
module tb_cgra_config_loader;
  import cgra_cfg_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic [1:0] rst = 2'b11;
  logic [1:0] start = 2'b00;
  logic [1:0] cfg_reset, shift_en, cfg_data, busy, done;

  logic        expq  [2][$];
  logic [31:0] hostq [2][$];
  int nshift [2];
  int nclr   [2];
  int hs_cnt [2];
  int gap_word [2];
  int gap_left [2];

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int L = (g == 0) ? 64 : 40;
    cgra_config_loader_if #(.WORD_W(W)) lif ();
    bit   took;
    logic e;

    cgra_config_loader #(.WORD_W(W), .CHAIN_LEN(L)) u_dut (
      .clk          (clk),
      .reset        (rst[g]),
      .start        (start[g]),
      .host         (lif.slave),
      .cfg_reset    (cfg_reset[g]),
      .cfg_shift_en (shift_en[g]),
      .cfg_data     (cfg_data[g]),
      .busy         (busy[g]),
      .done         (done[g])
    );

    // Host model: offers queued words, optionally withholding valid in one FETCH.
    initial begin
      took = 1'b0;
      lif.word_valid = 1'b0;
      lif.word_data  = '0;
      forever begin
        @(negedge clk);
        if (took && hostq[g].size() > 0) begin
          void'(hostq[g].pop_front());
          hs_cnt[g]++;
        end
        if (gap_left[g] > 0 && hs_cnt[g] == gap_word[g] && lif.word_ready) begin
          gap_left[g]--;
          lif.word_valid = 1'b0;
          vectors++;
          if (shift_en[g] !== 1'b0 || busy[g] !== 1'b1) begin
            errors++;
            $display("FAIL gap_freeze dut%0d: shift_en=%b busy=%b, required shift_en=0 busy=1", g, shift_en[g], busy[g]);
          end
        end else if (hostq[g].size() > 0) begin
          lif.word_valid = 1'b1;
          lif.word_data  = hostq[g][0];
        end else begin
          lif.word_valid = 1'b0;
          lif.word_data  = '0;
        end
        took = lif.word_valid && lif.word_ready;
      end
    end

    // Chain monitor: every enabled cycle pops one expected bit.
    initial forever begin
      @(negedge clk);
      if (cfg_reset[g]) nclr[g]++;
      vectors++;
      if (shift_en[g]) begin
        nshift[g]++;
        if (expq[g].size() == 0) begin
          errors++;
          $display("FAIL extra_bit dut%0d: shift %0d data=%b, required no shift", g, nshift[g], cfg_data[g]);
        end else begin
          e = expq[g].pop_front();
          if (cfg_data[g] !== e) begin
            errors++;
            $display("FAIL chain_bit dut%0d: bit %0d got %b, required %b", g, nshift[g] - 1, cfg_data[g], e);
          end
        end
      end else if (cfg_data[g] !== 1'b0) begin
        errors++;
        $display("FAIL idle_data dut%0d: cfg_data=%b while shift_en=0, required 0", g, cfg_data[g]);
      end
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic prep(input int g, input int len, input logic [31:0] w0, input logic [31:0] w1,
                      input logic [31:0] w2, input int nw);
    logic [31:0] w [3];
    logic [31:0] t;
    w[0] = w0; w[1] = w1; w[2] = w2;
    expq[g].delete();
    hostq[g].delete();
    for (int k = 0; k < len; k++) begin
      t = w[k / 32];
      expq[g].push_back(t[k % 32]);
    end
    for (int i = 0; i < nw; i++) hostq[g].push_back(w[i]);
    nshift[g] = 0;
    nclr[g]   = 0;
    hs_cnt[g] = 0;
  endtask

  task automatic pulse_start(input int g);
    start[g] = 1'b1;
    tick();
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int n0, output int n);
    n = n0;
    while (!done[g] && n < 400) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 2'b11;
    repeat (3) tick();
    rst = 2'b00;
    for (int g = 0; g < 2; g++) begin
      vectors++;
      if ({cfg_reset[g], shift_en[g], cfg_data[g], busy[g], done[g]} !== 5'b0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: {rst,en,data,busy,done}=%b, required 00000", g,
                 {cfg_reset[g], shift_en[g], cfg_data[g], busy[g], done[g]});
      end
    end
    vectors++;
    if (gen_dut[0].lif.word_ready !== 1'b0 || gen_dut[0].u_dut.state !== CFG_IDLE) begin
      errors++;
      $display("FAIL reset_state: word_ready=%b state=%0d, required 0 and IDLE", gen_dut[0].lif.word_ready,
               gen_dut[0].u_dut.state);
    end
  endtask

  task automatic test_full_load;
    int n;
    prep(0, 64, 32'hA5A5_0F0F, 32'h1234_5678, 32'h0, 2);
    tick();
    pulse_start(0);
    vectors++;
    if (cfg_reset[0] !== 1'b1 || busy[0] !== 1'b1 || gen_dut[0].lif.word_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_clear: cfg_reset=%b busy=%b ready=%b, required 1 1 0", cfg_reset[0], busy[0],
               gen_dut[0].lif.word_ready);
    end
    tick();
    vectors++;
    if (cfg_reset[0] !== 1'b0 || gen_dut[0].lif.word_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_fetch: cfg_reset=%b ready=%b at t+2, required 0 1", cfg_reset[0], gen_dut[0].lif.word_ready);
    end
    wait_done(0, 2, n);
    vectors++;
    if (n != 68 || nshift[0] != 64 || nclr[0] != 1 || expq[0].size() != 0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL full_load: done@t+%0d shifts=%0d clears=%0d left=%0d busy=%b, required 68 64 1 0 0", n,
               nshift[0], nclr[0], expq[0].size(), busy[0]);
    end
    repeat (3) tick();
    vectors++;
    if (done[0] !== 1'b1 || shift_en[0] !== 1'b0) begin
      errors++;
      $display("FAIL done_hold: done=%b shift_en=%b, required 1 0", done[0], shift_en[0]);
    end
  endtask

  task automatic test_start_in_done;
    int n;
    prep(0, 64, 32'hDEAD_BEEF, 32'h0F1E_2D3C, 32'h0, 2);
    pulse_start(0);
    vectors++;
    if (done[0] !== 1'b0 || cfg_reset[0] !== 1'b1) begin
      errors++;
      $display("FAIL restart_clear: done=%b cfg_reset=%b, required 0 1", done[0], cfg_reset[0]);
    end
    wait_done(0, 1, n);
    vectors++;
    if (n != 68 || nshift[0] != 64 || nclr[0] != 1 || expq[0].size() != 0) begin
      errors++;
      $display("FAIL restart_load: done@t+%0d shifts=%0d clears=%0d left=%0d, required 68 64 1 0", n, nshift[0],
               nclr[0], expq[0].size());
    end
  endtask

  task automatic test_backpressure;
    int n;
    prep(0, 64, 32'h8001_7FFE, 32'hC3C3_3C3C, 32'h0, 2);
    gap_word[0] = 1;
    gap_left[0] = 5;
    pulse_start(0);
    wait_done(0, 1, n);
    vectors++;
    if (n != 73 || nshift[0] != 64 || gap_left[0] != 0 || expq[0].size() != 0) begin
      errors++;
      $display("FAIL backpressure: done@t+%0d shifts=%0d gap_left=%0d left=%0d, required 73 64 0 0", n, nshift[0],
               gap_left[0], expq[0].size());
    end
  endtask

  task automatic test_start_during_shift;
    int n;
    prep(0, 64, 32'h0000_FFFF, 32'h5A5A_A5A5, 32'h0, 2);
    pulse_start(0);
    n = 1;
    while (nshift[0] < 10 && n < 200) begin
      tick();
      n++;
    end
    start[0] = 1'b1;
    tick();
    n++;
    start[0] = 1'b0;
    wait_done(0, n, n);
    vectors++;
    if (n != 68 || nclr[0] != 1 || nshift[0] != 64 || expq[0].size() != 0) begin
      errors++;
      $display("FAIL start_in_shift: done@t+%0d clears=%0d shifts=%0d left=%0d, required 68 1 64 0", n, nclr[0],
               nshift[0], expq[0].size());
    end
  endtask

  task automatic test_reset_mid;
    int n;
    prep(0, 64, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 2);
    pulse_start(0);
    n = 1;
    while (nshift[0] < 20 && n < 200) begin
      tick();
      n++;
    end
    tick();
    rst[0] = 1'b1;
    tick();
    vectors++;
    if ({cfg_reset[0], shift_en[0], cfg_data[0], busy[0], done[0], gen_dut[0].lif.word_ready} !== 6'b0 ||
        gen_dut[0].u_dut.state !== CFG_IDLE || nshift[0] != 21) begin
      errors++;
      $display("FAIL reset_mid: outs=%b state=%0d shifts=%0d, required 000000 IDLE 21",
               {cfg_reset[0], shift_en[0], cfg_data[0], busy[0], done[0], gen_dut[0].lif.word_ready},
               gen_dut[0].u_dut.state, nshift[0]);
    end
    rst[0] = 1'b0;
    prep(0, 64, 32'hA5A5_0F0F, 32'h1234_5678, 32'h0, 2);
    tick();
    pulse_start(0);
    vectors++;
    if (cfg_reset[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_reload_clear: cfg_reset=%b, required 1", cfg_reset[0]);
    end
    wait_done(0, 1, n);
    vectors++;
    if (n != 68 || nshift[0] != 64 || expq[0].size() != 0) begin
      errors++;
      $display("FAIL reset_reload: done@t+%0d shifts=%0d left=%0d, required 68 64 0", n, nshift[0], expq[0].size());
    end
  endtask

  task automatic test_partial_word;
    int n;
    prep(1, 40, 32'hFFFF_FFFF, 32'hFFFF_FF00, 32'h5555_5555, 3);
    pulse_start(1);
    wait_done(1, 1, n);
    repeat (4) tick();
    vectors++;
    if (n != 44 || nshift[1] != 40 || expq[1].size() != 0) begin
      errors++;
      $display("FAIL partial_load: done@t+%0d shifts=%0d left=%0d, required 44 40 0", n, nshift[1], expq[1].size());
    end
    vectors++;
    if (hs_cnt[1] != cfg_words(40, W) || hostq[1].size() != 1) begin
      errors++;
      $display("FAIL partial_extra_word: accepted=%0d pending=%0d, required %0d 1", hs_cnt[1], hostq[1].size(),
               cfg_words(40, W));
    end
  endtask

  initial begin
    gap_word = '{default: 0};
    gap_left = '{default: 0};
    test_reset();
    test_full_load();
    test_start_in_done();
    test_backpressure();
    test_start_during_shift();
    test_reset_mid();
    test_partial_word();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/cgra_config_loader.md
# cgra_config_loader

Single-clock bitstream loader for the CGRA configuration chain. It accepts configuration words from the host over a valid/ready interface and serialises them, one bit per cycle, onto the daisy-chained `config_in` of the PE/switch tiles. It also produces the chain-wide clear pulse and the shift enable that gates the tile configuration clock. It sits directly upstream of the first block PE's `config_in` port.

## Interface
- `WORD_W`, 32: host word width.
- `CHAIN_LEN`, 64: total configuration bits in the chain, in the range 1..4096.
- `CNT_W`, `$clog2(CHAIN_LEN+1)`: width of the bit counter.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
- `word_valid`  in  1  host word available.
- `word_data`  in  WORD_W  host word; bit 0 is shifted first.
- `word_ready`  out  1  loader accepts a word this cycle.
- `cfg_reset`  out  1  drives tile `config_reset`.
- `cfg_shift_en`  out  1  qualifies tile `config_clk`; one chain shift per cycle when high.
- `cfg_data`  out  1  drives the first tile's `config_in`.
- `busy`  out  1  high in CLEAR, FETCH and SHIFT.
- `done`  out  1  high in DONE, held until `start` or `reset`.

## Operation
- States are IDLE, CLEAR, FETCH, SHIFT and DONE.
- IDLE:
  - All outputs are 0.
  - `start` moves to CLEAR.
- CLEAR:
  - Lasts exactly 1 cycle, with `cfg_reset`=1.
  - Bit counter and word shift register are cleared.
  - Next state is FETCH.
- FETCH:
  - `word_ready`=1.
  - On `word_valid`&&`word_ready`, `word_data` is loaded into the shift register, the in-word count is set to min(WORD_W, CHAIN_LEN−bits_sent), and the state moves to SHIFT.
  - With no valid word, the loader stays in FETCH and the chain stays frozen (`cfg_shift_en`=0).
- SHIFT:
  - `cfg_shift_en`=1 and `cfg_data`=shreg[0] every cycle.
  - The register shifts right and bits_sent increments.
  - When the in-word count expires:
    - bits_sent==CHAIN_LEN moves to DONE.
    - Otherwise the loader returns to FETCH.
- Bit ordering: stream bit k is word k/WORD_W, bit k%WORD_W, emitted in increasing k.
- Last word: a partial final word emits only its low CHAIN_LEN%WORD_W bits. Its upper bits are discarded and never driven.
- Words required: ceil(CHAIN_LEN/WORD_W). Words offered beyond that are not accepted, because `word_ready` is 0 outside FETCH.
- DONE:
  - `done`=1.
  - `start` moves to CLEAR, which begins a fresh load with a new clear pulse.
- `start` in CLEAR, FETCH or SHIFT is ignored. It is not queued.
- `reset` in any state forces IDLE on the next edge, with all outputs 0 and counters 0. A partially shifted chain is left as is; the next load's CLEAR clears it.
- `cfg_data` is 0 whenever `cfg_shift_en`=0.
- Arithmetic: bits_sent is CNT_W bits and never wraps, since it saturates by construction at CHAIN_LEN.

## Timing
- All outputs are registered. Reset value of every output is 0.
- `start` sampled at edge t gives: CLEAR visible in cycle t+1, and FETCH (`word_ready`) in cycle t+2.
- A handshake in cycle f gives the first shifted bit in cycle f+1. A full word occupies cycles f+1..f+WORD_W.
- Minimum per word is 1 FETCH cycle plus the bits in that word. There is no prefetch overlap.
- Example, CHAIN_LEN=64, WORD_W=32, `word_valid` held high, `start` at t:
  - handshakes at t+2 and t+35;
  - shifts in t+3..t+34 and t+36..t+67;
  - `done` rises at t+68.
- `cfg_shift_en` must be ANDed into tile `config_clk` by a glitch-free clock gate at top level. The loader only guarantees the enable is registered.

## Structure
- Shared package `cgra_cfg_pkg` holds:
  - the state enum (`CFG_IDLE`, `CFG_CLEAR`, `CFG_FETCH`, `CFG_SHIFT`, `CFG_DONE`);
  - the default `CFG_WORD_W`=32;
  - a `cfg_words(len, w)` ceiling-divide function used here and by the host-side bitstream generator testbench model.
- Sub-module `cfg_piso`: a WORD_W parallel-in serial-out register with load, shift and remaining-count ports. The FSM and bits_sent counter stay in the top module.

## Test plan
- Full load: CHAIN_LEN=64, words 0xA5A5_0F0F and 0x1234_5678, `word_valid` held high.
  - `cfg_reset` is high exactly 1 cycle.
  - `cfg_data` sequence over 64 enabled cycles equals the words' bits, LSB first.
  - `done` rises at t+68.
- Partial word: CHAIN_LEN=40, words 0xFFFF_FFFF and 0xFFFF_FF00.
  - Exactly 40 `cfg_shift_en` cycles.
  - Last 8 bits are 0.
  - Second word's upper 24 bits are never emitted.
  - Third offered word is not accepted.
- Backpressure: `word_valid` low for 5 cycles in the second FETCH.
  - `cfg_shift_en` stays 0 and `busy` stays 1 during the gap.
  - Stream resumes bit-exact with total enabled cycles unchanged.
- `start` pulsed during SHIFT at bit 10: no extra CLEAR, the load completes normally, and `done` timing is unchanged.
- `reset` asserted at bit 20 of the first word:
  - next cycle, every output is 0 and the state is IDLE;
  - a subsequent `start` gives CLEAR, then a full 64-bit load matching the reference sequence.
- `start` in DONE: `done` drops, `cfg_reset` pulses, and a second bitstream loads correctly.
